// File: rtl/uart_pkg.sv
// Shared UART types: word width, word type and transmit-queue FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 9;

  typedef logic [UART_DATA_WIDTH-1:0] uart_word_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_LOW,
    WAIT_HIGH
  } txq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with separate occupancy count; full/empty decode the registered count.
// Latency: a push is visible to pop_data on the following cycle.
// Backpressure: push while full is ignored; pop while empty is ignored.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = UART_DATA_WIDTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Buffers 9-bit words and feeds UartTX one frame at a time via send/ready; optional UART_TX_QUEUE_OVERFLOW_EN adds overflow/drop_count.
// Latency: write in cycle N to an empty queue with UartTX idle pulses uart_send in cycle N+2.
// Backpressure: writes while full are dropped; a word is only launched when uart_ready is high in IDLE.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = UART_DATA_WIDTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  input  logic             uart_ready,
  output logic             uart_send,
  output logic [WIDTH-1:0] uart_data,
  output logic             busy
`ifdef UART_TX_QUEUE_OVERFLOW_EN
  ,
  output logic             overflow,
  output logic [7:0]       drop_count
`endif
);

  txq_state_t       state_q, state_d;
  logic [WIDTH-1:0] uart_data_q, uart_data_d;
  logic [WIDTH-1:0] pop_data;
  logic             pop;

  // The pop is the IDLE->SEND launch; full/empty come from the registered count.
  assign pop = (state_q == IDLE) && !empty && uart_ready;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    state_d     = state_q;
    uart_data_d = uart_data_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          uart_data_d = pop_data;
          state_d     = SEND;
        end
      end
      SEND:      state_d = WAIT_LOW;
      WAIT_LOW:  if (!uart_ready) state_d = WAIT_HIGH;
      WAIT_HIGH: if (uart_ready)  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      uart_data_q <= '0;
    end else begin
      state_q     <= state_d;
      uart_data_q <= uart_data_d;
    end
  end

  assign uart_send = (state_q == SEND);
  assign uart_data = uart_data_q;
  assign busy      = (state_q != IDLE);

`ifdef UART_TX_QUEUE_OVERFLOW_EN
  logic       overflow_q, overflow_d;
  logic [7:0] drop_count_q, drop_count_d;

  always_comb begin
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (wr_en && full) begin
      overflow_d = 1'b1;
      if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: directed vector table plus hand-written multi-cycle sequences
// against a behavioural UartTX model that drops ready after send and restores it a frame later.
module tb_uart_tx_queue;

  localparam int FRAME = 20;

  logic       clock;
  logic       reset;
  logic       wr_en;
  logic [8:0] wr_data;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       uart_ready;
  logic       uart_send;
  logic [8:0] uart_data;
  logic       busy;
`ifdef UART_TX_QUEUE_OVERFLOW_EN
  logic       overflow;
  logic [7:0] drop_count;
`endif

  uart_tx_queue #(.DEPTH(8), .WIDTH(9)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .uart_ready (uart_ready),
    .uart_send  (uart_send),
    .uart_data  (uart_data),
    .busy       (busy)
`ifdef UART_TX_QUEUE_OVERFLOW_EN
    ,
    .overflow   (overflow),
    .drop_count (drop_count)
`endif
  );

  int         tests = 0;
  int         failures = 0;
  int         cyc = 0;
  int         sends = 0;
  int         send_cyc = 0;
  int         busy_cnt = 0;
  logic       model_en = 1'b0;
  logic [8:0] rx_q[$];

  typedef struct {
    logic       wr;
    logic [8:0] dat;
    logic       rdy;
    logic [3:0] cnt;
    logic       emp;
    logic       ful;
    logic       snd;
    logic       bsy;
    logic [8:0] udat;
  } vec_t;

  vec_t vecs[17];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural UartTX: accepts on send, holds ready low for a frame, then idles.
  initial begin
    forever begin
      @(negedge clock);
      if (model_en) begin
        if (uart_send) begin
          sends++;
          send_cyc = cyc;
          rx_q.push_back(uart_data);
          check("send_while_ready", 32'(uart_ready), 32'd1);
          uart_ready = 1'b0;
          busy_cnt   = FRAME;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) uart_ready = 1'b1;
        end
      end
    end
  end

  task automatic wait_sends(input int target, input int max_cyc, input string name);
    int n;
    n = 0;
    while (sends < target && n < max_cyc) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(sends), 32'(target));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_count"}, 32'(count), 32'd0);
    check({name, "_flags"}, 32'({empty, full, uart_send, busy}), 32'b1000);
    check({name, "_data"}, 32'(uart_data), 32'd0);
`ifdef UART_TX_QUEUE_OVERFLOW_EN
    check({name, "_ovf"}, 32'({overflow, drop_count}), 32'd0);
`endif
  endtask

  initial begin
    logic [16:0] act_v;
    logic [16:0] exp_v;
    int          s0;
    int          n;
    logic [8:0]  next_w;

    //           wr  dat     rdy cnt emp ful snd bsy udat
    vecs[0]  = '{1'b1, 9'h1A5, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000};
    vecs[1]  = '{1'b1, 9'h0B2, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000};
    vecs[2]  = '{1'b0, 9'h000, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000};
    vecs[3]  = '{1'b0, 9'h000, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 9'h1A5};
    vecs[4]  = '{1'b0, 9'h000, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h1A5};
    vecs[5]  = '{1'b0, 9'h000, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h1A5};
    vecs[6]  = '{1'b0, 9'h000, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h1A5};
    vecs[7]  = '{1'b0, 9'h000, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h1A5};
    vecs[8]  = '{1'b0, 9'h000, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 9'h0B2};
    vecs[9]  = '{1'b1, 9'h033, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h0B2};
    vecs[10] = '{1'b0, 9'h000, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h0B2};
    vecs[11] = '{1'b0, 9'h000, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h0B2};
    vecs[12] = '{1'b0, 9'h000, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0B2};
    vecs[13] = '{1'b0, 9'h000, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 9'h033};
    vecs[14] = '{1'b0, 9'h000, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 9'h033};
    vecs[15] = '{1'b0, 9'h000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 9'h033};
    vecs[16] = '{1'b0, 9'h000, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h033};

    reset      = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;
    uart_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;

    // Table: ready held low with two words queued, then manual handshakes.
    for (int i = 0; i < 17; i++) begin
      wr_en      = vecs[i].wr;
      wr_data    = vecs[i].dat;
      uart_ready = vecs[i].rdy;
      @(negedge clock);
      act_v = {count, empty, full, uart_send, busy, uart_data};
      exp_v = {vecs[i].cnt, vecs[i].emp, vecs[i].ful, vecs[i].snd, vecs[i].bsy, vecs[i].udat};
      tests++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL vec%0d: got {cnt,e,f,s,b,data}=0x%0h, expected 0x%0h", i, act_v, exp_v);
      end
    end
    wr_en = 1'b0;

    // Single word latency with the UartTX model.
    uart_ready = 1'b1;
    busy_cnt   = 0;
    model_en   = 1'b1;
    rx_q.delete();
    s0 = sends;
    wr_en   = 1'b1;
    wr_data = 9'h1A5;
    n = cyc;
    @(negedge clock);
    wr_en = 1'b0;
    wait_sends(s0 + 1, 10, "single_send");
    check("single_latency", 32'(send_cyc - n), 32'd2);
    check("single_data", 32'(rx_q.size() > 0 ? rx_q[0] : 9'h1FF), 32'h1A5);
    check("single_empty_after", 32'(empty), 32'd1);

    // Burst fill while the transmitter is busy, then one write into a full queue.
    for (int i = 1; i <= 8; i++) begin
      wr_en   = 1'b1;
      wr_data = 9'(i);
      @(negedge clock);
    end
    check("burst_count", 32'(count), 32'd8);
    check("burst_full", 32'(full), 32'd1);
    wr_data = 9'h0FF;
    @(negedge clock);
    wr_en = 1'b0;
    check("overflow_count", 32'(count), 32'd8);
`ifdef UART_TX_QUEUE_OVERFLOW_EN
    check("overflow_flag", 32'(overflow), 32'd1);
    check("overflow_drops", 32'(drop_count), 32'd1);
`endif
    wait_sends(s0 + 9, 600, "burst_sends");
    repeat (FRAME + 10) @(negedge clock);
    check("burst_no_extra", 32'(sends), 32'(s0 + 9));
    check("burst_rx_size", 32'(rx_q.size()), 32'd9);
    for (int k = 1; k <= 8 && k < rx_q.size(); k++)
      check($sformatf("burst_order%0d", k), 32'(rx_q[k]), 32'(k));
    check("burst_drained", 32'(empty), 32'd1);

    // Simultaneous push and pop at count 3, then 20 words through the wrap.
    n = 0;
    while ((busy || busy_cnt != 0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    model_en   = 1'b0;
    uart_ready = 1'b0;
    rx_q.delete();
    s0 = sends;
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = 9'h100 + 9'(i);
      @(negedge clock);
    end
    check("pre_simul_count", 32'(count), 32'd3);
    model_en   = 1'b1;
    uart_ready = 1'b1;
    wr_data    = 9'h103;
    @(negedge clock);
    check("simul_count", 32'(count), 32'd3);
    check("simul_send", 32'(uart_send), 32'd1);
    next_w = 9'h104;
    n = 0;
    while (next_w <= 9'h113 && n < 2000) begin
      if (!full) begin
        wr_en   = 1'b1;
        wr_data = next_w;
        next_w  = next_w + 9'd1;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clock);
      n++;
    end
    wr_en = 1'b0;
    wait_sends(s0 + 20, 1000, "wrap_sends");
    for (int k = 0; k < 20 && k < rx_q.size(); k++)
      check($sformatf("wrap_order%0d", k), 32'(rx_q[k]), 32'h100 + 32'(k));

    // Reset while in WAIT_HIGH with four words still queued.
    n = 0;
    while ((busy || busy_cnt != 0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      wr_en   = 1'b1;
      wr_data = 9'h1E0 + 9'(i);
      @(negedge clock);
    end
    wr_en = 1'b0;
    repeat (3) @(negedge clock);
    check("pre_reset_count", 32'(count), 32'd4);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    reset      = 1'b0;
    model_en   = 1'b0;
    busy_cnt   = 0;
    uart_ready = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(negedge clock);
    reset    = 1'b1;
    model_en = 1'b1;
    s0 = sends;
    rx_q.delete();
    repeat (30) @(negedge clock);
    check("post_reset_quiet", 32'(sends), 32'(s0));
    check("post_reset_empty", 32'(empty), 32'd1);
    wr_en   = 1'b1;
    wr_data = 9'h055;
    @(negedge clock);
    wr_en = 1'b0;
    wait_sends(s0 + 1, 10, "post_reset_send");
    check("post_reset_data", 32'(rx_q.size() > 0 ? rx_q[0] : 9'h1FF), 32'h055);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Transmit-side buffer that sits directly upstream of UartTX in the 9N1 serial link.
- Accepts 9-bit words from the ATC control logic at any rate, stores them in a circular FIFO, and drains them one at a time into UartTX using UartTX's send/ready handshake.
- Decouples bursty producers from the slow serial line.

Parameters:
- DEPTH, 8: FIFO entries; power of two, >= 2.
- WIDTH, 9: word width; must match the UartTX data width (9).

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- wr_en  input  1  producer write strobe; one word per cycle.
- wr_data  input  WIDTH  word to enqueue.
- full  output  1  FIFO holds DEPTH words.
- empty  output  1  FIFO holds 0 words.
- count  output  $clog2(DEPTH+1)  current occupancy.
- uart_ready  input  1  connects to UartTX ready; high = transmitter idle.
- uart_send  output  1  connects to UartTX send; single-cycle pulse.
- uart_data  output  WIDTH  connects to UartTX data.
- busy  output  1  a word is in flight (state != IDLE).

Behaviour:
- Reset, asynchronous on reset low:
  - rd_ptr = 0, wr_ptr = 0, count = 0.
  - empty = 1, full = 0, uart_send = 0, uart_data = 0, busy = 0, state = IDLE.
  - Reset mid-transmission discards all queued words and the in-flight handshake. UartTX is reset by the same signal.
- Storage:
  - Memory array of DEPTH x WIDTH.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is tracked separately. full and empty are decoded combinationally from the registered count.
- Write: when wr_en=1 and full=0, store wr_data at wr_ptr, increment wr_ptr, increment count.
- Full: wr_en while full is dropped and pointers are unchanged. This holds even if a pop happens in the same cycle, because full is judged on the registered count.
- Pop: occurs only on the IDLE->SEND transition.
- Simultaneous write and pop: count is unchanged and both pointers advance.
- FSM states, one state register:
  - IDLE: if empty=0 and uart_ready=1, then uart_data <= mem[rd_ptr], increment rd_ptr, decrement count, go to SEND. Otherwise stay.
  - SEND: uart_send=1 for exactly this cycle; go to WAIT_LOW.
  - WAIT_LOW: stay until uart_ready=0, which means UartTX has accepted the word; then go to WAIT_HIGH.
  - WAIT_HIGH: stay until uart_ready=1 (stop bit finished); then go to IDLE.
- uart_send is the decoded (state==SEND), with no other sources.
- uart_data holds its value from the IDLE->SEND load until the next load. It is stable for the whole frame.
- Latency: a write in cycle N to an empty queue with UartTX idle gives uart_send=1 in cycle N+2.
- Throughput: back-to-back words re-enter SEND on the cycle after IDLE observes uart_ready=1. The minimum gap is one IDLE cycle between frames.
- busy = (state != IDLE).
- The queue never issues uart_send while uart_ready=0.

Optional Feature:
- Macro: UART_TX_QUEUE_OVERFLOW_EN.
- Defined:
  - Extra output port overflow (1 bit, sticky) and drop_count (8 bits, saturating at 255).
  - On every wr_en while full: overflow is set and drop_count increments.
  - Both clear only on reset.
- Undefined: both ports and their logic are absent, and dropped writes are silent.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_WIDTH = 9.
  - typedef logic [UART_DATA_WIDTH-1:0] uart_word_t.
  - enum txq_state_t {IDLE, SEND, WAIT_LOW, WAIT_HIGH}.
- One natural sub-module, sync_fifo:
  - Parameterised storage, pointers, count, full/empty.
  - Ports: push/push_data/pop/pop_data.
- The FSM and handshake stay in uart_tx_queue.

Test Plan:
- Reset low, then high; write 0x1A5 with a behavioural UartTX model (ready drops one cycle after send, returns after 10 bit times) -> uart_send pulses exactly once, 2 cycles after the write, with uart_data=0x1A5; empty=1 afterwards.
- Burst-write 0x001..0x008 on consecutive cycles (DEPTH=8) while the model is busy -> full=1 and count=8. Drain order is 0x001..0x008. Exactly 8 send pulses occur, each only while uart_ready=1.
- With the queue full, write 0x0FF -> count stays 8 and 0x0FF is never transmitted. With UART_TX_QUEUE_OVERFLOW_EN: overflow=1, drop_count=1.
- Write and pop in the same cycle with count=3 -> count stays 3 and both pointers advance. Across 20 words the pointer wrap preserves order.
- Assert reset low during WAIT_HIGH with 4 words queued -> all outputs return to reset values asynchronously. After release, no uart_send occurs until a new write.
- Hold uart_ready=0 from reset with 2 words queued -> no uart_send and state stays IDLE. Raise ready -> the first send follows on the next cycle.
